// File: rtl/stream_perm_db.sv
// Double-buffered streaming permutation over N-point frames on K lanes.
// One bank fills while the other drains; the mode travels with each frame.
module stream_perm_db #(
    parameter int W = 64,
    parameter int K = 2,
    parameter int N = 32,
    parameter int S = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           next,
    input  logic [1:0]     mode,
    input  logic [K*W-1:0] i_data,
    output logic           next_out,
    output logic [K*W-1:0] o_data,
    output logic           err
);

    localparam int B  = N / K;
    localparam int LB = $clog2(B);
    localparam int LN = $clog2(N);
    localparam int LS = $clog2(S);
    localparam logic [LB-1:0] LAST = LB'(B - 1);

    typedef enum logic { IN_IDLE, IN_FILL } in_state_t;
    typedef enum logic { OUT_IDLE, OUT_DRAIN } out_state_t;

    in_state_t     in_state, in_state_n;
    out_state_t    out_state, out_state_n;
    logic [LB-1:0] wc, rc;
    logic          alloc_bank, fill_bank, rd_bank;
    logic [1:0]    fill_mode, rd_mode;
    logic          accept, commit, spurious;
    logic [K*W-1:0] rd_beat;
    logic [W-1:0]  mem [2][N];

    function automatic logic [LN-1:0] elem_idx(input logic [LB-1:0] beat, input int lane);
        return LN'(int'(beat) * K + lane);
    endfunction

    // Source element for output position i; stride mode is a left rotation by log2(S).
    function automatic logic [LN-1:0] perm_idx(input logic [LN-1:0] i, input logic [1:0] m);
        logic [LN-1:0] r;
        r = i;
        case (m)
            2'd1: for (int b = 0; b < LN; b++) r[b] = i[LN-1-b];
            2'd2: r = (i << LS) | (i >> (LN - LS));
            2'd3: r = ~i;
            default: r = i;
        endcase
        return r;
    endfunction

    always_comb begin
        in_state_n = in_state;
        accept     = 1'b0;
        commit     = 1'b0;
        spurious   = 1'b0;
        case (in_state)
            IN_IDLE: begin
                if (next) begin
                    accept     = 1'b1;
                    in_state_n = IN_FILL;
                end
            end
            IN_FILL: begin
                if (wc == LAST) begin
                    commit = 1'b1;
                    if (next) accept = 1'b1;
                    else      in_state_n = IN_IDLE;
                end else if (next) begin
                    spurious = 1'b1;
                end
            end
            default: in_state_n = IN_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_state   <= IN_IDLE;
            wc         <= '0;
            alloc_bank <= 1'b0;
            fill_bank  <= 1'b0;
            fill_mode  <= 2'd0;
            err        <= 1'b0;
        end else begin
            in_state <= in_state_n;
            if (accept) begin
                fill_bank  <= alloc_bank;
                alloc_bank <= ~alloc_bank;
                fill_mode  <= mode;
                wc         <= '0;
            end else if (in_state == IN_FILL) begin
                wc <= wc + 1'b1;
            end
            if (spurious) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_state == IN_FILL) begin
            for (int l = 0; l < K; l++) begin
                mem[fill_bank][elem_idx(wc, l)] <= i_data[l*W +: W];
            end
        end
    end

    always_comb begin
        rd_beat = '0;
        for (int l = 0; l < K; l++) begin
            rd_beat[l*W +: W] = mem[rd_bank][perm_idx(elem_idx(rc, l), rd_mode)];
        end
    end

    // A commit always lands on the last drain beat or while idle, so drain never gaps.
    always_comb begin
        out_state_n = out_state;
        case (out_state)
            OUT_IDLE:  if (commit) out_state_n = OUT_DRAIN;
            OUT_DRAIN: if (rc == LAST && !commit) out_state_n = OUT_IDLE;
            default:   out_state_n = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_state <= OUT_IDLE;
            rc        <= '0;
            rd_bank   <= 1'b0;
            rd_mode   <= 2'd0;
            next_out  <= 1'b0;
            o_data    <= '0;
        end else begin
            out_state <= out_state_n;
            next_out  <= commit;
            if (commit) begin
                rc      <= '0;
                rd_bank <= fill_bank;
                rd_mode <= fill_mode;
            end else if (out_state == OUT_DRAIN) begin
                rc <= rc + 1'b1;
            end
            o_data <= (out_state == OUT_DRAIN) ? rd_beat : '0;
        end
    end

endmodule

// File: tb/tb_stream_perm_db.sv
// Bench for stream_perm_db: per-cycle stimulus/expectation tables filled from
// an index-level permutation model, then replayed and compared every cycle.
module tb_stream_perm_db;

    localparam int W    = 64;
    localparam int K    = 2;
    localparam int N    = 32;
    localparam int S    = 4;
    localparam int B    = N / K;
    localparam int MAXC = 256;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           next = 1'b0;
    logic [1:0]     mode = 2'd0;
    logic [K*W-1:0] i_data = '0;
    logic           next_out;
    logic [K*W-1:0] o_data;
    logic           err;

    stream_perm_db #(.W(W), .K(K), .N(N), .S(S)) dut (
        .clk(clk), .rst(rst), .next(next), .mode(mode), .i_data(i_data),
        .next_out(next_out), .o_data(o_data), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic           drv_next [MAXC];
    logic [1:0]     drv_mode [MAXC];
    logic [K*W-1:0] drv_data [MAXC];
    logic           exp_no   [MAXC];
    logic [K*W-1:0] exp_d    [MAXC];
    int             err_from;

    // Reference permutation straight from the index formulas.
    function automatic int ref_p(int i, int m);
        int r, x;
        case (m)
            1: begin
                r = 0; x = i;
                for (int b = 0; b < $clog2(N); b++) begin
                    r = r * 2 + x % 2;
                    x = x / 2;
                end
            end
            2: r = (i % (N / S)) * S + i / (N / S);
            3: r = N - 1 - i;
            default: r = i;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [K*W-1:0] got, input logic [K*W-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_seg();
        for (int c = 0; c < MAXC; c++) begin
            drv_next[c] = 1'b0;
            drv_mode[c] = 2'($urandom);
            drv_data[c] = {$urandom, $urandom, $urandom, $urandom};
            exp_no[c]   = 1'b0;
            exp_d[c]    = '0;
        end
        err_from = MAXC;
    endtask

    // next at cycle tn, beat 0 at tn+1, next_out at t0+B, output beat j at t0+B+1+j.
    task automatic add_frame(input int tn, input int m, input bit rnd, input longint base);
        logic [W-1:0] v [N];
        int t0;
        for (int e = 0; e < N; e++) v[e] = rnd ? {$urandom, $urandom} : W'(base + e);
        t0 = tn + 1;
        drv_next[tn] = 1'b1;
        drv_mode[tn] = 2'(m);
        for (int j = 0; j < B; j++) begin
            for (int l = 0; l < K; l++) begin
                drv_data[t0+j][l*W +: W]        = v[j*K+l];
                exp_d[t0+B+1+j][l*W +: W]       = v[ref_p(j*K+l, m)];
            end
        end
        exp_no[t0+B] = 1'b1;
    endtask

    task automatic check_cycle(input int c);
        chk($sformatf("next_out@%0d", c), {{(K*W-1){1'b0}}, next_out}, {{(K*W-1){1'b0}}, exp_no[c]});
        chk($sformatf("o_data@%0d", c), o_data, exp_d[c]);
        chk($sformatf("err@%0d", c), {{(K*W-1){1'b0}}, err}, {{(K*W-1){1'b0}}, (c >= err_from)});
    endtask

    task automatic run_seg(input int len);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            check_cycle(c);
            next   = drv_next[c];
            mode   = drv_mode[c];
            i_data = drv_data[c];
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_next_out"}, {{(K*W-1){1'b0}}, next_out}, '0);
        chk({tag, "_o_data"}, o_data, '0);
        chk({tag, "_err"}, {{(K*W-1){1'b0}}, err}, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        next = 1'b0;
        rst  = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int tn, gap, m;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("por");
        rst = 1'b1;

        // identity, index values
        clear_seg(); add_frame(1, 0, 1'b0, 0); run_seg(40);
        // bit reversal
        do_reset(); clear_seg(); add_frame(2, 1, 1'b0, 0); run_seg(40);
        // stride
        do_reset(); clear_seg(); add_frame(1, 2, 1'b0, 0); run_seg(40);
        // back-to-back: second next during first frame's beat 15
        do_reset(); clear_seg();
        add_frame(1, 0, 1'b0, 0); add_frame(1 + B, 3, 1'b0, 32); run_seg(60);
        // next re-asserted at beat 5 of a frame
        do_reset(); clear_seg();
        add_frame(1, 0, 1'b0, 0); drv_next[7] = 1'b1; err_from = 8; run_seg(45);

        // async reset during output beat 7, with err still set from before
        clear_seg(); err_from = 0; add_frame(2, 0, 1'b0, 0);
        run_seg(27);
        @(negedge clk);
        check_cycle(27);
        #1 rst = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        clear_seg(); run_seg(40);
        clear_seg(); add_frame(1, 0, 1'b0, 0); run_seg(40);

        // random data, modes and gaps
        repeat (3) begin
            do_reset(); clear_seg();
            tn = 1 + $urandom_range(0, 3);
            for (int f = 0; f < 6; f++) begin
                m = $urandom_range(0, 3);
                add_frame(tn, m, 1'b1, 0);
                gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5);
                tn  = tn + B + gap;
            end
            run_seg(tn + B + 4);
        end

        next = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
